// File: rtl/sdft_peak_detect_if.sv
// Bin stream in / power stream and peak report out for sdft_peak_detect.
// master drives bins (SDFT side), slave is the peak detector.
interface sdft_peak_detect_if #(
    parameter int IDW = 32,
    parameter int AW  = 12
);
    localparam int PW = 2 * IDW;

    logic [2*IDW-1:0] data_i;
    logic             sob_i;
    logic             eob_i;
    logic             valid_i;
    logic [PW-1:0]    threshold_i;

    logic [PW-1:0]    pwr_o;
    logic [AW-1:0]    pwr_idx_o;
    logic             pwr_sob_o;
    logic             pwr_eob_o;
    logic             pwr_valid_o;
    logic [AW-1:0]    peak_idx_o;
    logic [PW-1:0]    peak_pwr_o;
    logic             peak_found_o;
    logic             peak_valid_o;
    logic             frame_err_o;

    modport master (
        output data_i, sob_i, eob_i, valid_i, threshold_i,
        input  pwr_o, pwr_idx_o, pwr_sob_o, pwr_eob_o, pwr_valid_o,
        input  peak_idx_o, peak_pwr_o, peak_found_o, peak_valid_o, frame_err_o
    );

    modport slave (
        input  data_i, sob_i, eob_i, valid_i, threshold_i,
        output pwr_o, pwr_idx_o, pwr_sob_o, pwr_eob_o, pwr_valid_o,
        output peak_idx_o, peak_pwr_o, peak_found_o, peak_valid_o, frame_err_o
    );
endinterface

// File: rtl/sdft_peak_detect.sv
// Per-bin power (re^2+im^2) stream and per-block strongest-bin search on SDFT output.
// Latency: 3 cycles to the power stream, 4 cycles eob-to-report; no backpressure, a bin is taken every cycle.
module sdft_peak_detect #(
    parameter int IDW     = 32,
    parameter int AW      = 12,
    parameter bit SKIP_DC = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    sdft_peak_detect_if.slave bus
);
    localparam int PW = 2 * IDW;

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    logic [1:0] rst_sync_q;
    logic       rst_ok;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_ok = rst_sync_q[1];

    // Input-side bin counter; the index travels down the pipe with its bin.
    logic [AW-1:0] bin_cnt_q;
    logic [AW-1:0] bin_idx;
    assign bin_idx = bus.sob_i ? '0 : bin_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)         bin_cnt_q <= '0;
        else if (bus.valid_i) bin_cnt_q <= bin_idx + AW'(1);
    end

    // S1: register components, flags, index and threshold.
    logic                  s1_vld, s1_sob, s1_eob;
    logic signed [IDW-1:0] s1_re, s1_im;
    logic [AW-1:0]         s1_idx;
    logic [PW-1:0]         s1_thr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld <= 1'b0; s1_sob <= 1'b0; s1_eob <= 1'b0;
            s1_re  <= '0;   s1_im  <= '0;   s1_idx <= '0; s1_thr <= '0;
        end else begin
            s1_vld <= bus.valid_i;
            s1_sob <= bus.valid_i & bus.sob_i;
            s1_eob <= bus.valid_i & bus.eob_i;
            if (bus.valid_i) begin
                s1_re  <= bus.data_i[IDW-1:0];
                s1_im  <= bus.data_i[2*IDW-1:IDW];
                s1_idx <= bin_idx;
                s1_thr <= bus.threshold_i;
            end
        end
    end

    // S2: squares; -2**(IDW-1) squared is 2**(2*IDW-2), so the sign bit is always 0.
    logic signed [PW-1:0] re_ext, im_ext, re_sq, im_sq;
    assign re_ext = {{IDW{s1_re[IDW-1]}}, s1_re};
    assign im_ext = {{IDW{s1_im[IDW-1]}}, s1_im};
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;

    logic          s2_vld, s2_sob, s2_eob;
    logic [PW-1:0] s2_re_sq, s2_im_sq, s2_thr;
    logic [AW-1:0] s2_idx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_vld <= 1'b0; s2_sob <= 1'b0; s2_eob <= 1'b0;
            s2_re_sq <= '0; s2_im_sq <= '0; s2_idx <= '0; s2_thr <= '0;
        end else begin
            s2_vld <= s1_vld;
            s2_sob <= s1_sob;
            s2_eob <= s1_eob;
            if (s1_vld) begin
                s2_re_sq <= re_sq;
                s2_im_sq <= im_sq;
                s2_idx   <= s1_idx;
                s2_thr   <= s1_thr;
            end
        end
    end

    // S3: unsigned sum, at most 2**(PW-1), never overflows PW bits.
    logic          pwr_vld_q, pwr_sob_q, pwr_eob_q;
    logic [PW-1:0] pwr_q, s3_thr;
    logic [AW-1:0] pwr_idx_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pwr_vld_q <= 1'b0; pwr_sob_q <= 1'b0; pwr_eob_q <= 1'b0;
            pwr_q <= '0; pwr_idx_q <= '0; s3_thr <= '0;
        end else begin
            pwr_vld_q <= s2_vld;
            pwr_sob_q <= s2_sob;
            pwr_eob_q <= s2_eob;
            if (s2_vld) begin
                pwr_q     <= s2_re_sq + s2_im_sq;
                pwr_idx_q <= s2_idx;
                s3_thr    <= s2_thr;
            end
        end
    end

    // Peak search on the S3 beat; a sob beat starts from an empty best.
    state_t        state_q;
    logic [PW-1:0] thr_q, best_pwr_q;
    logic [AW-1:0] best_idx_q;
    logic          best_found_q;
    logic [PW-1:0] thr_cur, base_pwr, nxt_pwr;
    logic [AW-1:0] base_idx, nxt_idx;
    logic          base_found, nxt_found, cand, take;

    always_comb begin
        thr_cur    = pwr_sob_q ? s3_thr : thr_q;
        base_found = pwr_sob_q ? 1'b0 : best_found_q;
        base_pwr   = pwr_sob_q ? '0   : best_pwr_q;
        base_idx   = pwr_sob_q ? '0   : best_idx_q;
        cand       = pwr_vld_q && (pwr_q >= thr_cur) && !(SKIP_DC && (pwr_idx_q == '0));
        take       = cand && (!base_found || (pwr_q > base_pwr));
        nxt_found  = base_found | take;
        nxt_pwr    = take ? pwr_q     : base_pwr;
        nxt_idx    = take ? pwr_idx_q : base_idx;
    end

    logic [AW-1:0] peak_idx_q;
    logic [PW-1:0] peak_pwr_q;
    logic          peak_found_q, peak_vld_q, err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            thr_q        <= '0;
            best_pwr_q   <= '0;
            best_idx_q   <= '0;
            best_found_q <= 1'b0;
            peak_idx_q   <= '0;
            peak_pwr_q   <= '0;
            peak_found_q <= 1'b0;
            peak_vld_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            peak_vld_q <= 1'b0;
            if (!rst_ok) begin
                state_q <= IDLE;
            end else if (pwr_sob_q || (pwr_vld_q && state_q == ACCUM)) begin
                // A sob inside an open block abandons it unreported.
                if (pwr_sob_q && state_q == ACCUM) err_q <= 1'b1;
                if (pwr_sob_q) thr_q <= s3_thr;
                best_found_q <= nxt_found;
                best_pwr_q   <= nxt_pwr;
                best_idx_q   <= nxt_idx;
                // sob+eob on one beat passes through ACCUM within this same beat.
                if (pwr_eob_q) begin
                    state_q      <= REPORT;
                    peak_vld_q   <= 1'b1;
                    peak_found_q <= nxt_found;
                    peak_pwr_q   <= nxt_pwr;
                    peak_idx_q   <= nxt_idx;
                end else begin
                    state_q <= ACCUM;
                end
            end else begin
                if (pwr_vld_q && pwr_eob_q) err_q <= 1'b1;
                if (state_q == REPORT) state_q <= IDLE;
            end
        end
    end

    assign bus.pwr_o        = pwr_q;
    assign bus.pwr_idx_o    = pwr_idx_q;
    assign bus.pwr_sob_o    = pwr_sob_q;
    assign bus.pwr_eob_o    = pwr_eob_q;
    assign bus.pwr_valid_o  = pwr_vld_q;
    assign bus.peak_idx_o   = peak_idx_q;
    assign bus.peak_pwr_o   = peak_pwr_q;
    assign bus.peak_found_o = peak_found_q;
    assign bus.peak_valid_o = peak_vld_q;
    assign bus.frame_err_o  = err_q;
endmodule

// File: tb/tb_sdft_peak_detect.sv
// Directed bench for sdft_peak_detect: power stream values/latency and per-block peak reports.
module tb_sdft_peak_detect;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdft_peak_detect_if #(.IDW(32), .AW(12)) bus();

    sdft_peak_detect #(.IDW(32), .AW(12), .SKIP_DC(1'b1)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int          cyc;
        logic        found;
        logic [11:0] idx;
        logic [63:0] pwr;
    } rep_t;

    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 cyc = 0;
    int                 last_eob_cyc = 0;
    int                 pwr_eob_cyc = 0;
    int                 pwr_cnt = 0;
    rep_t               reps[$];
    logic [63:0]        pwr_log[0:15];
    logic signed [31:0] re_v[0:15];
    logic signed [31:0] im_v[0:15];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.pwr_valid_o) begin
            pwr_cnt++;
            if (bus.pwr_idx_o < 12'd16) pwr_log[bus.pwr_idx_o[3:0]] = bus.pwr_o;
            if (bus.pwr_eob_o) pwr_eob_cyc = cyc;
        end
        if (bus.peak_valid_o)
            reps.push_back('{cyc, bus.peak_found_o, bus.peak_idx_o, bus.peak_pwr_o});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic beat(input logic signed [31:0] re, input logic signed [31:0] im,
                        input logic sob, input logic eob);
        @(negedge clk);
        bus.data_i  = {im, re};
        bus.sob_i   = sob;
        bus.eob_i   = eob;
        bus.valid_i = 1'b1;
        if (eob) last_eob_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
            bus.sob_i   = 1'b0;
            bus.eob_i   = 1'b0;
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 16; i++) begin
            re_v[i] = 0;
            im_v[i] = 0;
            pwr_log[i] = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        pwr_cnt = 0;
    endtask

    task automatic send_block(input int n, input logic [63:0] thr);
        bus.threshold_i = thr;
        for (int i = 0; i < n; i++) beat(re_v[i], im_v[i], i == 0, i == n - 1);
    endtask

    // Exactly one new report since base, with the given content and eob-to-report latency of 4.
    task automatic check_report(input string tag, input int base, input logic found,
                                input logic [11:0] idx, input logic [63:0] pwr);
        check({tag, "_cnt"}, 64'(reps.size() - base), 64'd1);
        if (reps.size() > base) begin
            check({tag, "_found"}, 64'(reps[base].found), 64'(found));
            check({tag, "_idx"},   64'(reps[base].idx),   64'(idx));
            check({tag, "_pwr"},   reps[base].pwr,        pwr);
            check({tag, "_lat"},   64'(reps[base].cyc - last_eob_cyc), 64'd4);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pvld"},  64'(bus.pwr_valid_o),  64'd0);
        check({tag, "_pwr"},   bus.pwr_o,             64'd0);
        check({tag, "_kvld"},  64'(bus.peak_valid_o), 64'd0);
        check({tag, "_found"}, 64'(bus.peak_found_o), 64'd0);
        check({tag, "_kidx"},  64'(bus.peak_idx_o),   64'd0);
        check({tag, "_kpwr"},  bus.peak_pwr_o,        64'd0);
        check({tag, "_err"},   64'(bus.frame_err_o),  64'd0);
    endtask

    initial begin
        int base;
        bus.data_i = '0; bus.sob_i = 1'b0; bus.eob_i = 1'b0;
        bus.valid_i = 1'b0; bus.threshold_i = '0;
        clear_vec();
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(5);

        // One strong bin: (3,-4) -> 25
        clear_vec(); re_v[3] = 3; im_v[3] = -4;
        base = reps.size();
        send_block(8, 64'd1);
        idle(8);
        check("t1_pwr3", pwr_log[3], 64'd25);
        check("t1_pwr0", pwr_log[0], 64'd0);
        check("t1_pcnt", 64'(pwr_cnt), 64'd8);
        check("t1_plat", 64'(pwr_eob_cyc - last_eob_cyc), 64'd3);
        check_report("t1", base, 1'b1, 12'd3, 64'd25);

        // Tie: lowest index wins
        clear_vec(); re_v[2] = 100; re_v[5] = 100;
        base = reps.size();
        send_block(8, 64'd0);
        idle(8);
        check("t2_pwr5", pwr_log[5], 64'd10000);
        check_report("t2", base, 1'b1, 12'd2, 64'd10000);

        // DC bin skipped for search but present on power stream
        clear_vec(); re_v[0] = 1000; re_v[1] = 1; im_v[1] = 1;
        base = reps.size();
        send_block(4, 64'd0);
        idle(8);
        check("t3_pwr0", pwr_log[0], 64'd1000000);
        check_report("t3", base, 1'b1, 12'd1, 64'd2);

        // Nothing reaches threshold 50 (powers 0,2,8,18,32,...)
        clear_vec();
        for (int i = 0; i < 5; i++) begin re_v[i] = i; im_v[i] = i; end
        base = reps.size();
        send_block(8, 64'd50);
        idle(8);
        check("t4_pwr4", pwr_log[4], 64'd32);
        check_report("t4", base, 1'b0, 12'd0, 64'd0);

        // Single-beat block: only DC bin -> no candidate
        clear_vec(); re_v[0] = 7;
        base = reps.size();
        send_block(1, 64'd0);
        idle(8);
        check("t5_pwr0", pwr_log[0], 64'd49);
        check_report("t5", base, 1'b0, 12'd0, 64'd0);

        // Full-scale corner: (-2^31, -2^31) -> 2^63
        clear_vec(); re_v[1] = 32'sh8000_0000; im_v[1] = 32'sh8000_0000;
        base = reps.size();
        send_block(2, 64'd0);
        idle(8);
        check("t6_pwr1", pwr_log[1], 64'h8000_0000_0000_0000);
        check_report("t6", base, 1'b1, 12'd1, 64'h8000_0000_0000_0000);

        // Back-to-back blocks, sob right after eob
        clear_vec(); re_v[2] = 10;
        base = reps.size();
        send_block(4, 64'd0);
        clear_vec(); im_v[3] = 20;
        pwr_cnt = 0;
        send_block(4, 64'd0);
        idle(8);
        check("t7_pcnt", 64'(pwr_cnt), 64'd8);
        check("t7_pwr3", pwr_log[3], 64'd400);
        check("t7_cnt", 64'(reps.size() - base), 64'd2);
        if (reps.size() >= base + 2) begin
            check("t7a_idx", 64'(reps[base].idx), 64'd2);
            check("t7a_pwr", reps[base].pwr, 64'd100);
            check("t7b_idx", 64'(reps[base+1].idx), 64'd3);
            check("t7b_pwr", reps[base+1].pwr, 64'd400);
            check("t7_gap",  64'(reps[base+1].cyc - reps[base].cyc), 64'd4);
        end
        check("t7_err", 64'(bus.frame_err_o), 64'd0);

        // sob inside a block at bin 4: first part abandoned
        base = reps.size();
        bus.threshold_i = 64'd0;
        beat(0, 0, 1'b1, 1'b0);
        beat(50, 0, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 0, 1'b1, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(6, 8, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b1);
        idle(8);
        check("t8_err", 64'(bus.frame_err_o), 64'd1);
        check_report("t8", base, 1'b1, 12'd2, 64'd100);

        // eob with no open block: ignored
        base = reps.size();
        beat(9, 9, 1'b0, 1'b1);
        idle(8);
        check("t9_cnt", 64'(reps.size() - base), 64'd0);
        check("t9_err", 64'(bus.frame_err_o), 64'd1);
        check("t9_hold", 64'(bus.peak_idx_o), 64'd2);

        // Reset pulse mid-block
        base = reps.size();
        beat(0, 0, 1'b1, 1'b0);
        beat(30, 0, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        @(negedge clk);
        bus.valid_i = 1'b0; bus.sob_i = 1'b0; bus.eob_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        check_all_zero("rst_after");
        check("rst_cnt", 64'(reps.size() - base), 64'd0);

        // Normal operation from a fresh sob
        clear_vec(); im_v[1] = 9; re_v[2] = 3;
        base = reps.size();
        send_block(4, 64'd10);
        idle(8);
        check_report("t10", base, 1'b1, 12'd1, 64'd81);
        check("t10_err", 64'(bus.frame_err_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
